// File: rtl/ob_pixel_unpack_if.sv
// ----------------------------------------------------------------------------
// ob_pixel_unpack_if
//   Phrase channel from the object processor's bitmap latch to the pixel
//   unpacker. A phrase transfers on a clock where ph_valid && ph_ready.
//
//   ph_data   64  bitmap phrase, pixel 0 in the MSBs
//   ph_valid   1  phrase valid (producer)
//   ph_ready   1  phrase accepted (consumer)
//
//   master : producer side (object processor / testbench)
//   slave  : consumer side (ob_pixel_unpack)
// ----------------------------------------------------------------------------
interface ob_pixel_unpack_if;
  logic [63:0] ph_data;
  logic        ph_valid;
  logic        ph_ready;

  modport master (output ph_data, output ph_valid, input ph_ready);
  modport slave  (input ph_data, input ph_valid, output ph_ready);
endinterface

// File: rtl/ob_pixel_unpack.sv
// ----------------------------------------------------------------------------
// ob_pixel_unpack
//   Splits 64-bit bitmap phrases into pixels (MSB first, one per clock) and
//   issues line-buffer writes, stepping X up (or down when reflected).
//   Pulses done after dwidth phrases have been unpacked.
//
// Ports
//   clk, resetl              clock, asynchronous active-low reset
//   obj_start                latch object fields (IDLE only)
//   mode                     one-hot {24,16,8,4,2,1} bpp; anything else = 16 bpp
//   index[7:1]               palette base for 1/2/4 bpp
//   reflected, transen       X decrements / zero pixels not written
//   x_start, dwidth          first X position, phrases in this object line
//   ph                       phrase channel (slave modport)
//   abort                    line end: flush and return to IDLE
//   lb_we/lb_addr/lb_data    registered line-buffer write
//   lb_clut                  lb_data is a CLUT index
//   busy, done               state != IDLE, 1-clk end-of-object pulse
//
// 24 bpp pixels occupy 32-bit slots; the whole slot is passed on lb_data.
// ----------------------------------------------------------------------------
module ob_pixel_unpack #(
  parameter int LB_WIDTH = 720,
  parameter int XW       = 11
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             obj_start,
  input  logic [5:0]       mode,
  input  logic [7:1]       index,
  input  logic             reflected,
  input  logic             transen,
  input  logic [XW-1:0]    x_start,
  input  logic [9:0]       dwidth,
  ob_pixel_unpack_if.slave ph,
  input  logic             abort,
  output logic             lb_we,
  output logic [XW-1:0]    lb_addr,
  output logic [31:0]      lb_data,
  output logic             lb_clut,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [XW-1:0] LB_LIMIT = XW'(LB_WIDTH);
  localparam logic [XW-1:0] X_ONE    = XW'(1);

  state_e        state_q, state_d;

  // Latched object fields; lg_q is log2 of the pixel slot width
  logic [2:0]    lg_q;
  logic [7:1]    index_q;
  logic          refl_q;
  logic          transen_q;
  logic [XW-1:0] x_q;
  logic [9:0]    phr_left_q;
  logic [5:0]    pix_idx_q;

  // Two-entry phrase FIFO
  logic [63:0]   fifo_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;

  // Registered pixel outputs
  logic          lb_we_q,   lb_we_d;
  logic [XW-1:0] lb_addr_q, lb_addr_d;
  logic [31:0]   lb_data_q, lb_data_d;
  logic          lb_clut_q, lb_clut_d;
  logic          done_q,    done_d;

  logic          busy_s, fifo_full_s, fifo_empty_s;
  logic          push_s, pop_s, flush_s, emit_s, start_s, last_pix_s;
  logic [2:0]    lg_in_s;
  logic [63:0]   head_s;
  logic [6:0]    slot_end_s, shift_s;
  logic [31:0]   mask_s, pix_raw_s, pix_val_s;
  logic          in_range_s, transparent_s;

  assign busy_s       = (state_q != ST_IDLE);
  assign fifo_full_s  = (cnt_q == 2'd2);
  assign fifo_empty_s = (cnt_q == 2'd0);
  assign ph.ph_ready  = busy_s && !fifo_full_s;
  assign push_s       = ph.ph_valid && ph.ph_ready;
  assign start_s      = (state_q == ST_IDLE) && obj_start && !abort;
  assign emit_s       = (state_q == ST_RUN) && !fifo_empty_s && !abort;
  assign last_pix_s   = (pix_idx_q == (6'd63 >> lg_q));
  assign pop_s        = emit_s && last_pix_s;
  // Leaving DONE empties the FIFO so phrases taken past dwidth never leak into the next object
  assign flush_s      = abort || (state_q == ST_DONE);

  assign head_s        = fifo_q[rd_ptr_q];
  // Pixel k occupies bits [64-w*k-1 : 64-w*(k+1)]
  assign slot_end_s    = ({1'b0, pix_idx_q} + 7'd1) << lg_q;
  assign shift_s       = 7'd64 - slot_end_s;
  assign pix_raw_s     = 32'(head_s >> shift_s) & mask_s;
  assign in_range_s    = (x_q < LB_LIMIT);
  assign transparent_s = transen_q && (pix_raw_s == 32'd0);

  assign lb_we   = lb_we_q;
  assign lb_addr = lb_addr_q;
  assign lb_data = lb_data_q;
  assign lb_clut = lb_clut_q;
  assign busy    = busy_s;
  assign done    = done_q;

  // Mode decode: exactly one bit set selects the depth, otherwise 16 bpp
  always_comb begin
    lg_in_s = 3'd4;
    case (mode)
      6'b000001: lg_in_s = 3'd0;
      6'b000010: lg_in_s = 3'd1;
      6'b000100: lg_in_s = 3'd2;
      6'b001000: lg_in_s = 3'd3;
      6'b010000: lg_in_s = 3'd4;
      6'b100000: lg_in_s = 3'd5;
      default:   lg_in_s = 3'd4;
    endcase
  end

  // Pixel mask and CLUT index / direct colour formation
  always_comb begin
    mask_s    = 32'hFFFF_FFFF;
    pix_val_s = 32'd0;
    case (lg_q)
      3'd0:    mask_s = 32'h0000_0001;
      3'd1:    mask_s = 32'h0000_0003;
      3'd2:    mask_s = 32'h0000_000F;
      3'd3:    mask_s = 32'h0000_00FF;
      3'd4:    mask_s = 32'h0000_FFFF;
      default: mask_s = 32'hFFFF_FFFF;
    endcase
    case (lg_q)
      3'd0:    pix_val_s = {24'd0, index_q[7:1], pix_raw_s[0]};
      3'd1:    pix_val_s = {24'd0, index_q[7:2], pix_raw_s[1:0]};
      3'd2:    pix_val_s = {24'd0, index_q[7:4], pix_raw_s[3:0]};
      3'd3:    pix_val_s = {24'd0, pix_raw_s[7:0]};
      default: pix_val_s = pix_raw_s;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (obj_start) begin
            state_d = (dwidth == 10'd0) ? ST_DONE : ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pop_s && (phr_left_q == 10'd1)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM output logic: next values of the registered write port and done
  always_comb begin
    lb_we_d   = 1'b0;
    lb_addr_d = lb_addr_q;
    lb_data_d = lb_data_q;
    lb_clut_d = lb_clut_q;
    done_d    = (state_q == ST_DONE) && !abort;
    if (emit_s) begin
      lb_we_d   = in_range_s && !transparent_s;
      lb_addr_d = x_q;
      lb_data_d = pix_val_s;
      lb_clut_d = (lg_q <= 3'd3);
    end else begin
      lb_we_d   = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      lb_we_q   <= 1'b0;
      lb_addr_q <= '0;
      lb_data_q <= 32'd0;
      lb_clut_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      lb_we_q   <= lb_we_d;
      lb_addr_q <= lb_addr_d;
      lb_data_q <= lb_data_d;
      lb_clut_q <= lb_clut_d;
      done_q    <= done_d;
    end
  end

  // Object fields, X position and per-phrase pixel counter
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      lg_q       <= 3'd0;
      index_q    <= 7'd0;
      refl_q     <= 1'b0;
      transen_q  <= 1'b0;
      x_q        <= '0;
      phr_left_q <= 10'd0;
      pix_idx_q  <= 6'd0;
    end else if (start_s) begin
      lg_q       <= lg_in_s;
      index_q    <= index;
      refl_q     <= reflected;
      transen_q  <= transen;
      x_q        <= x_start;
      phr_left_q <= dwidth;
      pix_idx_q  <= 6'd0;
    end else if (emit_s) begin
      // X steps even for suppressed pixels; wraps modulo 2^XW
      x_q       <= refl_q ? (x_q - X_ONE) : (x_q + X_ONE);
      pix_idx_q <= last_pix_s ? 6'd0 : (pix_idx_q + 6'd1);
      if (last_pix_s) begin
        phr_left_q <= phr_left_q - 10'd1;
      end
    end
  end

  // Phrase FIFO storage and pointers
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      fifo_q[0] <= 64'd0;
      fifo_q[1] <= 64'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else if (flush_s) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q] <= ph.ph_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule
